alarm_control_unit: RTL

ALARM_CONTROL_UNIT -- requirements
Module: alarm_control_unit

---
 rtl/alarm_control_unit.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/alarm_control_unit.sv
// Alarm clock controller: time/day/alarm set modes, alarm trigger, ring with snooze and auto-stop.
// All outputs registered; strobes appear one Clk after the button edge or Tick that causes them.
module alarm_control_unit #(
  parameter int NUM_ALARMS    = 2,
  parameter int SNOOZE_TICKS  = 5,
  parameter int RING_TICKS    = 60,
  parameter int MAX_SNOOZE    = 3,
  parameter int TIMEOUT_TICKS = 30,
  localparam int AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Next,
  input  logic                  Up,
  input  logic                  SetTime,
  input  logic                  SetDay,
  input  logic                  SetAlarm,
  input  logic                  Snooze,
  input  logic                  Stop,
  input  logic                  Tick,
  input  logic [NUM_ALARMS-1:0] Match,
  output logic                  INCR,
  output logic                  LD_DAY_TIME,
  output logic                  Load,
  output logic                  Clear_St,
  output logic [1:0]            Field,
  output logic [AW-1:0]         AlarmSel,
  output logic [NUM_ALARMS-1:0] AlarmEn,
  output logic                  Ring,
  output logic                  Busy
);

  localparam int TMAX_A = (RING_TICKS > TIMEOUT_TICKS) ? RING_TICKS : TIMEOUT_TICKS;
  localparam int TMAX   = (TMAX_A > SNOOZE_TICKS) ? TMAX_A : SNOOZE_TICKS;
  localparam int CW     = $clog2(TMAX + 2);
  localparam int SW     = $clog2(MAX_SNOOZE + 2);

  localparam int B_NEXT = 0, B_UP = 1, B_SETTIME = 2, B_SETDAY = 3,
                 B_SETALARM = 4, B_SNOOZE = 5, B_STOP = 6;

  localparam logic [1:0] F_NONE = 2'b00, F_HOUR = 2'b01, F_MIN = 2'b10, F_DAY = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE, S_T_HR, S_T_MIN, S_DAY, S_A_SEL, S_A_HR, S_A_MIN, S_RING, S_SNOOZE
  } state_t;

  state_t                state_q, state_d;
  logic [6:0]            btn_prev_q, btn_prev_d;
  logic                  armed_q, armed_d;
  logic [CW-1:0]         tmr_q, tmr_d;
  logic [SW-1:0]         snz_q, snz_d;
  logic [AW-1:0]         sel_q, sel_d;
  logic [NUM_ALARMS-1:0] en_q, en_d;
  logic                  incr_q, incr_d, ld_q, ld_d, load_q, load_d, clr_q, clr_d;
  logic [1:0]            field_q, field_d;
  logic                  ring_q, ring_d, busy_q, busy_d;

  logic [6:0]            btn, btn_rise;
  logic                  any_rise, is_set, tmr_expire;
  logic [CW-1:0]         tmr_dec;
  logic [NUM_ALARMS-1:0] hit;
  logic [AW-1:0]         trig_sel;

  assign btn = {Stop, Snooze, SetAlarm, SetDay, SetTime, Up, Next};
  // The first cycle after reset only samples buttons, so a button held through release is not an edge.
  assign btn_rise   = armed_q ? (btn & ~btn_prev_q) : 7'd0;
  assign any_rise   = |btn_rise;
  assign tmr_dec    = (tmr_q != '0) ? tmr_q - CW'(1) : '0;
  assign tmr_expire = Tick && (tmr_q <= CW'(1));
  assign hit        = Match & en_q;
  assign is_set     = (state_q == S_T_HR) || (state_q == S_T_MIN) || (state_q == S_DAY) ||
                      (state_q == S_A_SEL) || (state_q == S_A_HR) || (state_q == S_A_MIN);

  always_comb begin
    trig_sel = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (hit[i]) trig_sel = AW'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    snz_d      = snz_q;
    sel_d      = sel_q;
    en_d       = en_q;
    incr_d     = 1'b0;
    ld_d       = 1'b0;
    load_d     = 1'b0;
    clr_d      = 1'b0;
    btn_prev_d = btn;
    armed_d    = 1'b1;

    // Set-mode inactivity timeout; per-state button handling below overrides it.
    if (is_set) begin
      if (any_rise) begin
        tmr_d = CW'(TIMEOUT_TICKS);
      end else if (Tick) begin
        tmr_d = tmr_dec;
        if (tmr_expire) state_d = S_IDLE;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (btn_rise[B_SETTIME]) begin
          state_d = S_T_HR;
          tmr_d   = CW'(TIMEOUT_TICKS);
        end else if (btn_rise[B_SETDAY]) begin
          state_d = S_DAY;
          tmr_d   = CW'(TIMEOUT_TICKS);
        end else if (btn_rise[B_SETALARM]) begin
          state_d = S_A_SEL;
          sel_d   = '0;
          tmr_d   = CW'(TIMEOUT_TICKS);
        end else if (Tick && (|hit)) begin
          state_d = S_RING;
          sel_d   = trig_sel;
          tmr_d   = CW'(RING_TICKS);
        end
      end
      S_T_HR: begin
        if (btn_rise[B_NEXT])    state_d = S_T_MIN;
        else if (btn_rise[B_UP]) incr_d = 1'b1;
      end
      S_T_MIN, S_DAY: begin
        if (btn_rise[B_NEXT]) begin
          state_d = S_IDLE;
          ld_d    = 1'b1;
        end else if (btn_rise[B_UP]) begin
          incr_d = 1'b1;
        end
      end
      S_A_SEL: begin
        if (btn_rise[B_NEXT]) begin
          state_d = S_A_HR;
        end else if (btn_rise[B_SETALARM]) begin
          en_d[sel_q] = 1'b0;
          state_d     = S_IDLE;
        end else if (btn_rise[B_UP]) begin
          sel_d = (sel_q == AW'(NUM_ALARMS - 1)) ? '0 : sel_q + AW'(1);
        end
      end
      S_A_HR: begin
        if (btn_rise[B_NEXT])    state_d = S_A_MIN;
        else if (btn_rise[B_UP]) incr_d = 1'b1;
      end
      S_A_MIN: begin
        if (btn_rise[B_NEXT]) begin
          state_d     = S_IDLE;
          load_d      = 1'b1;
          en_d[sel_q] = 1'b1;
        end else if (btn_rise[B_UP]) begin
          incr_d = 1'b1;
        end
      end
      S_RING: begin
        if (btn_rise[B_STOP]) begin
          state_d = S_IDLE;
          clr_d   = 1'b1;
        end else if (btn_rise[B_SNOOZE] && (snz_q < SW'(MAX_SNOOZE))) begin
          state_d = S_SNOOZE;
          snz_d   = snz_q + SW'(1);
          tmr_d   = CW'(SNOOZE_TICKS);
        end else if (Tick) begin
          tmr_d = tmr_dec;
          if (tmr_expire) begin
            state_d = S_IDLE;
            clr_d   = 1'b1;
          end
        end
      end
      S_SNOOZE: begin
        if (btn_rise[B_STOP]) begin
          state_d = S_IDLE;
          clr_d   = 1'b1;
        end else if (Tick) begin
          tmr_d = tmr_dec;
          if (tmr_expire) begin
            state_d = S_RING;
            tmr_d   = CW'(RING_TICKS);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_IDLE) begin
      snz_d = '0;
      tmr_d = '0;
    end

    unique case (state_d)
      S_T_HR, S_A_HR:  field_d = F_HOUR;
      S_T_MIN, S_A_MIN: field_d = F_MIN;
      S_DAY:           field_d = F_DAY;
      default:         field_d = F_NONE;
    endcase
    ring_d = (state_d == S_RING);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= S_IDLE;
      btn_prev_q <= '0;
      armed_q    <= 1'b0;
      tmr_q      <= '0;
      snz_q      <= '0;
      sel_q      <= '0;
      en_q       <= '0;
      incr_q     <= 1'b0;
      ld_q       <= 1'b0;
      load_q     <= 1'b0;
      clr_q      <= 1'b0;
      field_q    <= F_NONE;
      ring_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      btn_prev_q <= btn_prev_d;
      armed_q    <= armed_d;
      tmr_q      <= tmr_d;
      snz_q      <= snz_d;
      sel_q      <= sel_d;
      en_q       <= en_d;
      incr_q     <= incr_d;
      ld_q       <= ld_d;
      load_q     <= load_d;
      clr_q      <= clr_d;
      field_q    <= field_d;
      ring_q     <= ring_d;
      busy_q     <= busy_d;
    end
  end

  assign INCR        = incr_q;
  assign LD_DAY_TIME = ld_q;
  assign Load        = load_q;
  assign Clear_St    = clr_q;
  assign Field       = field_q;
  assign AlarmSel    = sel_q;
  assign AlarmEn     = en_q;
  assign Ring        = ring_q;
  assign Busy        = busy_q;

endmodule
